// File: rtl/round_arbiter.sv
// Round-robin arbiter feeding one shared round-to-nearest-even datapath with a registered valid/ready output.
// Optional ROUND_STATS_EN adds saturating inexact/carry transfer counters.
module round_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [NUM_REQ*11-1:0]  req_mant_i,
    input  logic [NUM_REQ*8-1:0]   req_exp_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [7:0]             out_mant_o,
    output logic [7:0]             out_exp_o,
    output logic [ID_W-1:0]        out_id_o
`ifdef ROUND_STATS_EN
    ,
    output logic [15:0]            stat_inexact_o,
    output logic [15:0]            stat_carry_o
`endif
);

    localparam int unsigned MANT_W = 11;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned RES_W  = 8;

    logic [ID_W-1:0]   last_q;
    logic              slot_free_c;
    logic              grant_c;
    logic [ID_W-1:0]   grant_id_c;
    logic [MANT_W-1:0] sel_mant_c;
    logic [EXP_W-1:0]  sel_exp_c;
    logic [RES_W:0]    base_c;
    logic              inc_c;
    logic [RES_W:0]    r_c;
    logic [RES_W-1:0]  res_mant_c;
    logic [EXP_W-1:0]  res_exp_c;

    // Round-robin search starting just after the last winner; no grant during reset or while the slot is busy.
    always_comb begin
        int unsigned w;
        req_ready_o = '0;
        grant_c     = 1'b0;
        grant_id_c  = '0;
        sel_mant_c  = '0;
        sel_exp_c   = '0;
        w           = 0;
        slot_free_c = !out_valid_o || out_ready_i;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w = 32'(last_q) + 32'd1 + i;
            if (w >= NUM_REQ) begin
                w = w - NUM_REQ;
            end
            if (!grant_c && req_valid_i[w]) begin
                grant_c    = 1'b1;
                grant_id_c = ID_W'(w);
                sel_mant_c = req_mant_i[w*MANT_W +: MANT_W];
                sel_exp_c  = req_exp_i[w*EXP_W +: EXP_W];
            end
        end
        if (rst || !slot_free_c) begin
            grant_c = 1'b0;
        end
        if (grant_c) begin
            req_ready_o[grant_id_c] = 1'b1;
        end
    end

    // Nearest-even: round up above the halfway point, or at the tie when the kept LSB is odd.
    always_comb begin
        base_c     = {1'b0, sel_mant_c[MANT_W-1:3]};
        inc_c      = sel_mant_c[2] & (sel_mant_c[1] | sel_mant_c[0] | sel_mant_c[3]);
        r_c        = base_c + (RES_W+1)'(inc_c);
        res_mant_c = r_c[RES_W] ? r_c[RES_W:1] : r_c[RES_W-1:0];
        res_exp_c  = sel_exp_c + EXP_W'(r_c[RES_W]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q      <= ID_W'(NUM_REQ - 1);
            out_valid_o <= 1'b0;
            out_mant_o  <= '0;
            out_exp_o   <= '0;
            out_id_o    <= '0;
        end else if (grant_c) begin
            last_q      <= grant_id_c;
            out_valid_o <= 1'b1;
            out_mant_o  <= res_mant_c;
            out_exp_o   <= res_exp_c;
            out_id_o    <= grant_id_c;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

`ifdef ROUND_STATS_EN
    // Saturating event counters, bumped in the accept cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_inexact_o <= '0;
            stat_carry_o   <= '0;
        end else if (grant_c) begin
            if ((|sel_mant_c[2:0]) && (stat_inexact_o != 16'hFFFF)) begin
                stat_inexact_o <= stat_inexact_o + 16'd1;
            end
            if (r_c[RES_W] && (stat_carry_o != 16'hFFFF)) begin
                stat_carry_o <= stat_carry_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_round_arbiter.sv
// Self-checking bench for round_arbiter: directed steps plus randomized traffic against an arithmetic reference model.
module tb_round_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ID_W    = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid;
    logic [10:0]           mant [NUM_REQ];
    logic [7:0]            expo [NUM_REQ];
    logic [NUM_REQ*11-1:0] req_mant;
    logic [NUM_REQ*8-1:0]  req_exp;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [7:0]            out_mant;
    logic [7:0]            out_exp;
    logic [ID_W-1:0]       out_id;
`ifdef ROUND_STATS_EN
    logic [15:0]           stat_inexact;
    logic [15:0]           stat_carry;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int          m_last;
    bit          m_valid;
    bit          m_known;
    logic [7:0]  m_mant;
    logic [7:0]  m_exp;
    int          m_id;
    int          m_inexact;
    int          m_carry;
    int          last_grant;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            req_mant[k*11 +: 11] = mant[k];
            req_exp[k*8 +: 8]    = expo[k];
        end
    end

    round_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_mant_i  (req_mant),
        .req_exp_i   (req_exp),
        .req_ready_o (req_ready),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_mant_o  (out_mant),
        .out_exp_o   (out_exp),
        .out_id_o    (out_id)
`ifdef ROUND_STATS_EN
        ,
        .stat_inexact_o (stat_inexact),
        .stat_carry_o   (stat_carry)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round to nearest-even with integer arithmetic on the 11-bit value (3 fraction bits).
    task automatic mround(input logic [10:0] m, input logic [7:0] e,
                          output logic [7:0] om, output logic [7:0] oe, output bit carry);
        int q;
        int rem;
        q   = int'(m) / 8;
        rem = int'(m) % 8;
        if (rem > 4 || (rem == 4 && (q % 2) == 1)) q = q + 1;
        carry = (q >= 256);
        if (carry) begin
            om = 8'(q / 2);
            oe = 8'((int'(e) + 1) % 256);
        end else begin
            om = 8'(q);
            oe = e;
        end
    endtask

    function automatic int mgrant(input logic [NUM_REQ-1:0] v, input int last, input bit free);
        if (!free) return -1;
        for (int i = 1; i <= NUM_REQ; i++) begin
            int k;
            k = (last + i) % NUM_REQ;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_last    = NUM_REQ - 1;
        m_valid   = 0;
        m_known   = 1;
        m_mant    = '0;
        m_exp     = '0;
        m_id      = 0;
        m_inexact = 0;
        m_carry   = 0;
    endtask

    // One clock: check the combinational grant, advance the model across the edge, then check outputs.
    task automatic cycle();
        int g;
        logic [NUM_REQ-1:0] er;
        logic [7:0] om;
        logic [7:0] oe;
        bit carry;
        #1;
        g  = rst ? -1 : mgrant(req_valid, m_last, !m_valid || out_ready);
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(er));
        last_grant = g;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (g >= 0) begin
            mround(mant[g], expo[g], om, oe, carry);
            m_valid = 1;
            m_known = 1;
            m_mant  = om;
            m_exp   = oe;
            m_id    = g;
            m_last  = g;
            if (mant[g][2:0] != 3'b000 && m_inexact < 65535) m_inexact++;
            if (carry && m_carry < 65535) m_carry++;
        end else if (out_ready) begin
            m_valid = 0;
            m_known = 0;
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_known) begin
            chk("out_mant", 32'(out_mant), 32'(m_mant));
            chk("out_exp", 32'(out_exp), 32'(m_exp));
            chk("out_id", 32'(out_id), 32'(m_id));
        end
`ifdef ROUND_STATS_EN
        chk("stat_inexact", 32'(stat_inexact), 32'(m_inexact));
        chk("stat_carry", 32'(stat_carry), 32'(m_carry));
`endif
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        req_valid = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            mant[k] = '0;
            expo[k] = '0;
        end
        model_reset();
        @(posedge clk);
        #1;
        cycle();
        cycle();
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_mant", 32'(out_mant), 32'd0);
        rst = 1'b0;

        // Tie with odd LSB rounds up
        mant[0] = 11'b10110011_100; expo[0] = 8'h40; req_valid = 4'b0001;
        cycle();
        req_valid = '0;
        chk("tie_odd_mant", 32'(out_mant), 32'hB4);
        chk("tie_odd_exp", 32'(out_exp), 32'h40);
        chk("tie_odd_id", 32'(out_id), 32'd0);

        // Tie with even LSB holds
        mant[0] = 11'b10110010_100; req_valid = 4'b0001;
        cycle();
        req_valid = '0;
        chk("tie_even_mant", 32'(out_mant), 32'hB2);

        // Below halfway truncates
        mant[0] = 11'b10110010_011; req_valid = 4'b0001;
        cycle();
        req_valid = '0;
        chk("trunc_mant", 32'(out_mant), 32'hB2);

        // Carry-out renormalises
        mant[1] = 11'b11111111_101; expo[1] = 8'h40; req_valid = 4'b0010;
        cycle();
        req_valid = '0;
        chk("carry_mant", 32'(out_mant), 32'h80);
        chk("carry_exp", 32'(out_exp), 32'h41);
        chk("carry_id", 32'(out_id), 32'd1);

        // Exponent wraps
        expo[1] = 8'hFF; req_valid = 4'b0010;
        cycle();
        req_valid = '0;
        chk("wrap_exp", 32'(out_exp), 32'h00);

        // Full round-robin after reset
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            mant[k] = 11'(k * 40 + 3);
            expo[k] = 8'(k + 16);
        end
        req_valid = '1;
        for (int c = 0; c < 8; c++) begin
            cycle();
            chk("rr_id", 32'(out_id), 32'(c % NUM_REQ));
            chk("rr_valid", 32'(out_valid), 32'd1);
        end
        req_valid = '0;
        cycle();

        // Stall with req2 pending, then drain and accept together
        out_ready = 1'b0;
        mant[0] = 11'h2A5; expo[0] = 8'h10; req_valid = 4'b0001;
        cycle();
        req_valid = 4'b0100; mant[2] = 11'h3F4; expo[2] = 8'h22;
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("stall_ready", 32'(req_ready), 32'd0);
            chk("stall_id", 32'(out_id), 32'd0);
        end
        out_ready = 1'b1;
        cycle();
        req_valid = '0;
        chk("drain_accept_valid", 32'(out_valid), 32'd1);
        chk("drain_accept_id", 32'(out_id), 32'd2);

        // Reset while holding a result and with requests pending
        out_ready = 1'b0;
        mant[3] = 11'h155; req_valid = 4'b1000;
        cycle();
        req_valid = 4'b1010;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_mant", 32'(out_mant), 32'd0);
        chk("mid_rst_id", 32'(out_id), 32'd0);
`ifdef ROUND_STATS_EN
        chk("mid_rst_inexact", 32'(stat_inexact), 32'd0);
        chk("mid_rst_carry", 32'(stat_carry), 32'd0);
`endif
        out_ready = 1'b1;
        cycle();
        chk("post_rst_first_id", 32'(out_id), 32'd1);
        req_valid[1] = 1'b0;
        cycle();
        req_valid = '0;

        // Randomized traffic; requesters hold their payload until accepted
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!req_valid[k] && $urandom_range(0, 2) != 0) begin
                    req_valid[k] = 1'b1;
                    mant[k] = 11'($urandom);
                    if ($urandom_range(0, 3) == 0) mant[k][2:0] = 3'b100;
                    if ($urandom_range(0, 5) == 0) mant[k][10:3] = 8'hFF;
                    expo[k] = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 99) == 0);
            cycle();
            if (last_grant >= 0) req_valid[last_grant] = 1'b0;
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
